reg_file_dump_reader: RTL and testbench
=======================================

Name: reg_file_dump_reader

Overview:
- Read-side initiator for the 8x8 register file.
- On START, walks R0..R7 through one register-file read port: drives the address, waits for the read to settle, captures the value, then presents it on a valid/ready stream (debug/trace sink or testbench scoreboard).
- Leaves the second read port and the write port for the datapath, so a dump can run while the CPU is active.

Parameters:
- NUM_REGS, 8, number of registers walked (R0..NUM_REGS-1).
- ADDR_W, 3, register address width; 2**ADDR_W >= NUM_REGS.
- DATA_W, 8, register data width (signed two's complement).
- SETTLE_CYCLES, 1, whole CLK cycles RF_ADDR is held before capture; covers the register file's asynchronous read delay; minimum 1.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request a full dump; sampled at posedge.
- RF_ADDR  out  ADDR_W  address driven to a register-file read port.
- RF_DATA  in  DATA_W  signed read data returned from that port.
- OUT_DATA  out  DATA_W  captured register value.
- OUT_INDEX  out  ADDR_W  register number of OUT_DATA.
- OUT_VALID  out  1  OUT_DATA/OUT_INDEX valid.
- OUT_READY  in  1  sink accepts the beat when OUT_VALID && OUT_READY at posedge.
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Interface: reset is RESET, synchronous, active-high; clock is CLK.
- RESET has priority over every other input at the posedge.
  - State goes to IDLE.
  - RF_ADDR=0, OUT_DATA=0, OUT_INDEX=0, OUT_VALID=0, BUSY=0, DONE=0; settle counter and index cleared.
  - Applies mid-dump: the in-flight beat is dropped and no DONE is issued.
- IDLE:
  - START=1 at a posedge: idx=0, RF_ADDR=0, cnt=0, BUSY=1, go to SETTLE.
  - Otherwise hold. DONE is cleared on the cycle after its pulse.
- SETTLE:
  - cnt increments each posedge.
  - When cnt reaches SETTLE_CYCLES-1 at a posedge, go to CAPTURE.
  - RF_ADDR holds idx throughout.
- CAPTURE (one cycle):
  - At the posedge, OUT_DATA<=RF_DATA, OUT_INDEX<=idx, OUT_VALID<=1; go to PRESENT.
  - Latency: START edge k gives first OUT_VALID after edge k+SETTLE_CYCLES+1.
- PRESENT:
  - OUT_DATA and OUT_INDEX stay stable while OUT_VALID=1 && OUT_READY=0 (no drop, no change).
  - On OUT_READY=1 at a posedge, OUT_VALID<=0.
    - If idx==NUM_REGS-1: go to IDLE, BUSY<=0, DONE<=1.
    - Else: idx<=idx+1, RF_ADDR<=idx+1, cnt<=0, go to SETTLE.
- Throughput: one beat per SETTLE_CYCLES+2 cycles when OUT_READY is held high.
- START while BUSY: ignored; never restarts or queues a dump.
- START in the DONE-pulse cycle (state IDLE): accepted, so back-to-back dumps are allowed.
- Coherency: none. Each register is sampled at its own CAPTURE edge. A write to R[idx] is seen if it settles before that edge, and is never seen once the beat is captured.
- Index handling: idx compares against NUM_REGS-1 exactly; no wrap to R0 within a dump.
- Data is passed through unmodified; the signed value is never extended or truncated.

Decomposition:
- Shared package (regfile_pkg): RF_ADDR_W=3, RF_DATA_W=8, RF_NUM_REGS=8, and the state encoding for IDLE, SETTLE, CAPTURE, PRESENT.
  - The register file, this reader, and the datapath control unit all take their widths from this package.
- Single module. The settle counter and index counter are small enough to stay inline, so no sub-module.

Test Plan:
- Preload R0..R7 = 0,28,95,0,15,0,0,50; pulse START with OUT_READY=1 -> 8 beats (0,0),(1,28),(2,95),(3,0),(4,15),(5,0),(6,0),(7,50), beats SETTLE_CYCLES+2 cycles apart, one DONE pulse, BUSY low the cycle after.
- Backpressure: hold OUT_READY=0 for 5 cycles on beat 2 -> OUT_VALID=1 and OUT_DATA=95, OUT_INDEX=2 stable throughout; no beat lost or duplicated.
- Concurrent write: write R4=6 before beat 4 captures, then R4=15 after -> beat 4 carries 6.
- START pulses during BUSY -> ignored (exactly 8 beats, one DONE); START in the DONE cycle -> second dump starts immediately.
- RESET asserted while PRESENT at idx=3 -> next cycle all outputs 0, no DONE; a later START dumps from R0.
- Signed value R7=-3'd1-style 8'hFF (-1) -> beat 7 OUT_DATA=8'hFF unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and dump-reader state encoding for the 8x8 register file,
// its reader, and the datapath control unit.
package regfile_pkg;

  localparam int RF_ADDR_W   = 3;
  localparam int RF_DATA_W   = 8;
  localparam int RF_NUM_REGS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PRESENT = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_file_dump_reader.sv
// Walks R0..NUM_REGS-1 through one register-file read port and streams each
// captured value out on a valid/ready interface.
module reg_file_dump_reader
  import regfile_pkg::*;
#(
  parameter int NUM_REGS      = RF_NUM_REGS,
  parameter int ADDR_W        = RF_ADDR_W,
  parameter int DATA_W        = RF_DATA_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  output logic        [ADDR_W-1:0] RF_ADDR,
  input  logic signed [DATA_W-1:0] RF_DATA,
  output logic signed [DATA_W-1:0] OUT_DATA,
  output logic        [ADDR_W-1:0] OUT_INDEX,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);

  dump_state_e               state_q;
  logic        [ADDR_W-1:0] idx_q;
  logic        [ADDR_W-1:0] idx_d;
  logic        [CNT_W-1:0]  cnt_q;
  logic        [ADDR_W-1:0] rf_addr_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic        [ADDR_W-1:0] out_index_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic                     done_q;

  assign idx_d = idx_q + ADDR_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      rf_addr_q   <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            idx_q     <= '0;
            rf_addr_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SETTLE;
          end
        end
        // RF_ADDR has been stable for cnt_q+1 edges; capture once it has settled
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_CAPTURE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          out_data_q  <= RF_DATA;
          out_index_q <= idx_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            if (idx_q == IDX_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              idx_q     <= idx_d;
              rf_addr_q <= idx_d;
              cnt_q     <= '0;
              state_q   <= ST_SETTLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RF_ADDR   = rf_addr_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_INDEX = out_index_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Scoreboard bench for reg_file_dump_reader: expected beats are queued per dump
// and a negedge monitor pops and compares every accepted beat.
module tb_reg_file_dump_reader;
  import regfile_pkg::*;

  localparam int NR = RF_NUM_REGS;
  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;
  localparam int SC = 1;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 START;
  logic        [AW-1:0] RF_ADDR;
  logic signed [DW-1:0] RF_DATA;
  logic signed [DW-1:0] OUT_DATA;
  logic        [AW-1:0] OUT_INDEX;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic                 BUSY;
  logic                 DONE;

  logic signed [DW-1:0] rf [NR];
  assign RF_DATA = rf[RF_ADDR];

  always #5 CLK = ~CLK;

  reg_file_dump_reader #(
    .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(SC)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA),
    .OUT_DATA(OUT_DATA), .OUT_INDEX(OUT_INDEX),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    cyc      = 0;
  int    done_cnt = 0;
  int    prev_acc = -1;
  bit    spacing_en = 1'b0;

  logic [DW-1:0] t_base [NR] = '{8'd0, 8'd28, 8'd95, 8'd0, 8'd15, 8'd0, 8'd0, 8'd50};
  logic [DW-1:0] t_wr   [NR] = '{8'd0, 8'd28, 8'd95, 8'd0, 8'd6,  8'd0, 8'd0, 8'd50};
  logic [DW-1:0] t_neg  [NR] = '{8'd0, 8'd28, 8'd95, 8'd0, 8'd15, 8'd0, 8'd0, 8'hFF};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_dump(input logic [DW-1:0] v [NR]);
    for (int i = 0; i < NR; i++) exp_q.push_back(beat_t'{AW'(i), v[i]});
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic wait_valid(input int idx, input string name);
    int n = 0;
    while (!(OUT_VALID && OUT_INDEX == AW'(idx)) && n < 40) begin
      step();
      n++;
    end
    check(name, {OUT_VALID, OUT_INDEX}, {1'b1, AW'(idx)});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!DONE && n < 80) begin
      step();
      n++;
    end
    check(name, DONE, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rf_addr"}, RF_ADDR, 0);
    check({tag, "_out_data"}, $unsigned(OUT_DATA), 0);
    check({tag, "_out_index"}, OUT_INDEX, 0);
    check({tag, "_out_valid"}, OUT_VALID, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
  endtask

  // Monitor: a beat is taken when VALID && READY are seen ahead of a non-reset edge
  initial forever begin
    beat_t e;
    @(negedge CLK);
    if (DONE) done_cnt++;
    if (OUT_VALID && OUT_READY && !RESET) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got idx %0d data %0h expected no beat", OUT_INDEX, OUT_DATA);
      end else begin
        e = exp_q.pop_front();
        check("beat_idx", OUT_INDEX, e.idx);
        check("beat_data", $unsigned(OUT_DATA), e.data);
      end
      if (spacing_en && prev_acc >= 0) check("beat_spacing", cyc - prev_acc, SC + 2);
      prev_acc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    RESET = 1'b1;
    START = 1'b0;
    OUT_READY = 1'b0;
    for (int i = 0; i < NR; i++) rf[i] = t_base[i];
    step();
    step();
    check_zero_outputs("reset");
    RESET = 1'b0;
    step();

    // Full dump with READY held high: latency, spacing, DONE/BUSY
    OUT_READY = 1'b1;
    spacing_en = 1'b1;
    push_dump(t_base);
    pulse_start();
    check("t1_busy", BUSY, 1);
    check("t1_valid_k", OUT_VALID, 0);
    step();
    check("t1_valid_k1", OUT_VALID, 0);
    check("t1_rf_addr", RF_ADDR, 0);
    step();
    check("t1_first_valid", {OUT_VALID, OUT_INDEX}, {1'b1, AW'(0)});
    wait_done("t1_done");
    step();
    check("t1_busy_after", BUSY, 0);
    check("t1_done_cleared", DONE, 0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_queue_empty", exp_q.size(), 0);
    spacing_en = 1'b0;
    prev_acc = -1;

    // Backpressure on beat 2, concurrent write to R4 around its capture
    OUT_READY = 1'b0;
    push_dump(t_wr);
    pulse_start();
    for (int b = 0; b < 2; b++) begin
      wait_valid(b, "t2_wait_beat");
      OUT_READY = 1'b1;
      step();
      OUT_READY = 1'b0;
    end
    wait_valid(2, "t2_wait_beat2");
    for (int c = 0; c < 5; c++) begin
      step();
      check("t2_hold_valid", OUT_VALID, 1);
      check("t2_hold_data", $unsigned(OUT_DATA), 95);
      check("t2_hold_index", OUT_INDEX, 2);
    end
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    wait_valid(3, "t3_wait_beat3");
    rf[4] = 8'sd6;
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    wait_valid(4, "t3_wait_beat4");
    rf[4] = 8'sd15;
    step();
    check("t3_captured_hold", $unsigned(OUT_DATA), 6);
    OUT_READY = 1'b1;
    wait_done("t3_done");
    step();
    check("t3_done_cnt", done_cnt, 2);
    check("t3_queue_empty", exp_q.size(), 0);

    // START spam while busy is ignored; START in the DONE cycle restarts
    push_dump(t_base);
    pulse_start();
    START = 1'b1;
    repeat (10) step();
    START = 1'b0;
    wait_done("t4_done");
    START = 1'b1;
    push_dump(t_base);
    step();
    START = 1'b0;
    check("t4_restart_busy", BUSY, 1);
    check("t4_done_cnt", done_cnt, 3);
    wait_done("t4_done2");
    step();
    check("t4_done_cnt2", done_cnt, 4);
    check("t4_queue_empty", exp_q.size(), 0);

    // Reset while presenting beat 3: beat dropped, no DONE
    push_dump(t_base);
    pulse_start();
    wait_valid(3, "t5_wait_beat3");
    OUT_READY = 1'b0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_zero_outputs("t5_reset");
    check("t5_pending", exp_q.size(), 5);
    exp_q.delete();
    dc = done_cnt;
    repeat (10) step();
    check("t5_no_done", done_cnt, dc);
    check("t5_idle_valid", OUT_VALID, 0);

    // Fresh dump from R0 with a negative value in R7
    rf[7] = 8'shFF;
    push_dump(t_neg);
    OUT_READY = 1'b1;
    pulse_start();
    wait_done("t6_done");
    step();
    check("t6_done_cnt", done_cnt, dc + 1);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
